// File: rtl/status_pkg.sv
// Shared constants and decode helper for the rstatus ($r30) unit.
// Combinational only; no latency.
// No flow control; pure definitions.
package status_pkg;

  // Opcodes seen at writeback
  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SETX = 5'b10101;

  // R-type ALU codes
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Overflow cause codes written into rstatus (zero-extended)
  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_ADD  = 3'd1,
    CAUSE_ADDI = 3'd2,
    CAUSE_SUB  = 3'd3,
    CAUSE_MUL  = 3'd4,
    CAUSE_DIV  = 3'd5
  } cause_e;

  // Map an instruction plus its overflow flag to a cause; CAUSE_NONE when
  // the instruction cannot overflow or did not.
  function automatic cause_e decode_cause(input logic [4:0] opcode,
                                          input logic [4:0] alu_code,
                                          input logic       overflow);
    cause_e c;
    c = CAUSE_NONE;
    if (overflow) begin
      if (opcode == OP_ADDI) begin
        c = CAUSE_ADDI;
      end else if (opcode == OP_R) begin
        case (alu_code)
          ALU_ADD: c = CAUSE_ADD;
          ALU_SUB: c = CAUSE_SUB;
          ALU_MUL: c = CAUSE_MUL;
          ALU_DIV: c = CAUSE_DIV;
          default: c = CAUSE_NONE;
        endcase
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/status_hist_fifo.sv
// Cause-history FIFO: DEPTH x DATA_W, drops oldest entry when pushed while full.
// Latency: push visible on head/count one edge later; head is combinational from storage.
// Backpressure: none; push always accepted (overwrite), pop on empty ignored.
// Ports: clock/reset (sync, active-high); clear resets only the overrun flag;
//   push/push_dat write, pop consumes head; valid/head/count/overrun status.
module status_hist_fifo #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_dat,
  input  logic                       pop,
  output logic                       valid,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              full, pop_eff, drop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign pop_eff = pop && valid;
  // A push into a full FIFO with no pop evicts the head to make room.
  assign drop    = push && full && !pop_eff;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovr_d = ovr_q;
    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop_eff || drop) rd_d = rd_q + PTR_W'(1);
    if (push && !pop_eff && !full) cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (pop_eff && !push)     cnt_d = cnt_q - (PTR_W+1)'(1);
    if (clear)     ovr_d = 1'b0;
    else if (drop) ovr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end

  // Storage needs no reset: head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_q] <= push_dat;
  end

  assign head    = valid ? mem_q[rd_q] : '0;
  assign count   = cnt_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/status_unit.sv
// rstatus ($r30) unit: decodes overflow causes / setx at writeback into a status word,
// with saturating overflow count, cause-history FIFO and status_next forwarding for bex.
// Latency: status_out/status_we one edge after the en cycle; status_next combinational.
// Backpressure: none; history FIFO overwrites oldest on full and flags hist_overrun.
// Ports: clock/reset, writeback instr (en/opcode/alu_code/target/overflow), clear,
//   hist_pop; outputs status_out/next/we, hist_* FIFO view, ovf_count.
module status_unit
  import status_pkg::*;
#(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [4:0]             opcode,
  input  logic [4:0]             alu_code,
  input  logic [DATA_W-1:0]      target,
  input  logic                   overflow,
  input  logic                   clear,
  input  logic                   hist_pop,
  output logic [DATA_W-1:0]      status_out,
  output logic [DATA_W-1:0]      status_next,
  output logic                   status_we,
  output logic                   hist_valid,
  output logic [DATA_W-1:0]      hist_cause,
  output logic [$clog2(DEPTH):0] hist_count,
  output logic                   hist_overrun,
  output logic [CNT_W-1:0]       ovf_count
);
  logic [DATA_W-1:0] status_q, status_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cause_e            cause;
  logic              is_setx, cause_evt, push;

  assign cause     = en ? decode_cause(opcode, alu_code, overflow) : CAUSE_NONE;
  assign is_setx   = en && (opcode == OP_SETX);
  assign cause_evt = (cause != CAUSE_NONE);
  // clear discards the same-cycle instruction, including its history push.
  assign push      = cause_evt && !clear;

  // Priority: clear > setx > cause > hold (reset handled in the register).
  always_comb begin
    status_d = status_q;
    we_d     = 1'b0;
    cnt_d    = cnt_q;
    if (clear) begin
      status_d = '0;
      we_d     = 1'b1;
      cnt_d    = '0;
    end else if (is_setx) begin
      status_d = target;
      we_d     = 1'b1;
    end else if (cause_evt) begin
      status_d = DATA_W'(cause);
      we_d     = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      status_q <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      status_q <= status_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  // Forwarded value must match what the register will hold, so reset forces 0.
  assign status_next = reset ? '0 : status_d;
  assign status_out  = status_q;
  assign status_we   = we_q;
  assign ovf_count   = cnt_q;

  status_hist_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_hist (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .push     (push),
    .push_dat (DATA_W'(cause)),
    .pop      (hist_pop),
    .valid    (hist_valid),
    .head     (hist_cause),
    .count    (hist_count),
    .overrun  (hist_overrun)
  );

endmodule

// File: tb/tb_status_unit.sv
// Directed bench for status_unit with a queue-based reference model and scoreboard.
// Expected results are queued when stimulus is driven and popped after the edge.
// A second instance with CNT_W=2 checks counter saturation.
module tb_status_unit;

  logic        clock = 1'b0;
  logic        reset, en, overflow, clear, hist_pop;
  logic [4:0]  opcode, alu_code;
  logic [26:0] target;

  logic [26:0] status_out, status_next, hist_cause;
  logic        status_we, hist_valid, hist_overrun;
  logic [2:0]  hist_count;
  logic [7:0]  ovf_count;

  logic [26:0] s2_out, s2_next, s2_cause;
  logic        s2_we, s2_valid, s2_overrun;
  logic [2:0]  s2_count;
  logic [1:0]  s2_ovf;

  always #5 clock = ~clock;

  status_unit #(.DATA_W(27), .DEPTH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .en(en), .opcode(opcode), .alu_code(alu_code),
    .target(target), .overflow(overflow), .clear(clear), .hist_pop(hist_pop),
    .status_out(status_out), .status_next(status_next), .status_we(status_we),
    .hist_valid(hist_valid), .hist_cause(hist_cause), .hist_count(hist_count),
    .hist_overrun(hist_overrun), .ovf_count(ovf_count)
  );

  status_unit #(.DATA_W(27), .DEPTH(4), .CNT_W(2)) dut_c2 (
    .clock(clock), .reset(reset), .en(en), .opcode(opcode), .alu_code(alu_code),
    .target(target), .overflow(overflow), .clear(clear), .hist_pop(hist_pop),
    .status_out(s2_out), .status_next(s2_next), .status_we(s2_we),
    .hist_valid(s2_valid), .hist_cause(s2_cause), .hist_count(s2_count),
    .hist_overrun(s2_overrun), .ovf_count(s2_ovf)
  );

  typedef struct packed {
    logic [26:0] st;
    logic        we;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
    logic        hv;
    logic [26:0] head;
    logic [2:0]  hc;
    logic        ov;
  } exp_t;

  exp_t        exq[$];
  logic [26:0] mq[$];
  logic [26:0] m_st;
  logic        m_we, m_ov;
  logic [7:0]  m_cnt;
  logic [1:0]  m_cnt2;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mpop(input logic pop);
    if (pop && mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic step(input logic r, input logic e, input logic [4:0] op,
                      input logic [4:0] alu, input logic [26:0] tgt,
                      input logic ov, input logic clr, input logic pop);
    exp_t        x;
    logic [26:0] c;
    reset = r; en = e; opcode = op; alu_code = alu; target = tgt;
    overflow = ov; clear = clr; hist_pop = pop;

    c = '0;
    if (e && ov && op == 5'b00000) begin
      case (alu)
        5'b00000: c = 27'd1;
        5'b00001: c = 27'd3;
        5'b00110: c = 27'd4;
        5'b00111: c = 27'd5;
        default:  c = 27'd0;
      endcase
    end
    if (e && ov && op == 5'b00101) c = 27'd2;

    if (r) begin
      m_st = '0; m_we = 1'b0; m_cnt = '0; m_cnt2 = '0; m_ov = 1'b0;
      mq.delete();
    end else if (clr) begin
      m_st = '0; m_we = 1'b1; m_cnt = '0; m_cnt2 = '0; m_ov = 1'b0;
      mpop(pop);
    end else if (e && op == 5'b10101) begin
      m_st = tgt; m_we = 1'b1;
      mpop(pop);
    end else if (c != 0) begin
      m_st = c; m_we = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
      if (pop && mq.size() > 0) begin
        void'(mq.pop_front());
      end else if (mq.size() == 4) begin
        void'(mq.pop_front());
        m_ov = 1'b1;
      end
      mq.push_back(c);
    end else begin
      m_we = 1'b0;
      mpop(pop);
    end

    x.st   = m_st;
    x.we   = m_we;
    x.cnt  = m_cnt;
    x.cnt2 = m_cnt2;
    x.hv   = (mq.size() > 0);
    x.head = (mq.size() > 0) ? mq[0] : 27'd0;
    x.hc   = 3'(mq.size());
    x.ov   = m_ov;
    exq.push_back(x);

    #1;
    chk("status_next", 32'(status_next), 32'(m_st));
    @(posedge clock);
    #1;
    x = exq.pop_front();
    chk("status_out",   32'(status_out),   32'(x.st));
    chk("status_we",    32'(status_we),    32'(x.we));
    chk("ovf_count",    32'(ovf_count),    32'(x.cnt));
    chk("ovf_count_c2", 32'(s2_ovf),       32'(x.cnt2));
    chk("hist_valid",   32'(hist_valid),   32'(x.hv));
    chk("hist_cause",   32'(hist_cause),   32'(x.head));
    chk("hist_count",   32'(hist_count),   32'(x.hc));
    chk("hist_overrun", 32'(hist_overrun), 32'(x.ov));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; opcode = '0; alu_code = '0; target = '0;
    overflow = 1'b0; clear = 1'b0; hist_pop = 1'b0;
    m_st = '0; m_we = 1'b0; m_cnt = '0; m_cnt2 = '0; m_ov = 1'b0;
    @(posedge clock);
    #1;

    // 1: reset held with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 5'($urandom), 5'($urandom), 27'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));

    // 2: each overflow cause; fifth push overwrites the oldest entry
    step(0, 1, 5'b00000, 5'b00000, 27'h0, 1, 0, 0);   // add
    step(0, 1, 5'b00101, 5'b01010, 27'h0, 1, 0, 0);   // addi
    step(0, 1, 5'b00000, 5'b00001, 27'h0, 1, 0, 0);   // sub
    step(0, 1, 5'b00000, 5'b00110, 27'h0, 1, 0, 0);   // mul
    step(0, 1, 5'b00000, 5'b00111, 27'h0, 1, 0, 0);   // div -> overrun, head 2

    // 3: setx, then setx together with clear, then idle and equal-value setx
    step(0, 1, 5'b10101, 5'b00000, 27'h0F1, 0, 0, 0);
    step(0, 1, 5'b10101, 5'b00000, 27'h0F1, 0, 1, 0);
    step(0, 0, 5'b00000, 5'b00000, 27'h0, 0, 0, 0);
    step(0, 1, 5'b10101, 5'b00000, 27'h0, 1, 0, 0);

    // 4: non-arith opcode with overflow, and en=0 with add overflow
    step(0, 1, 5'b00011, 5'b00000, 27'h0, 1, 0, 0);
    step(0, 0, 5'b00000, 5'b00000, 27'h0, 1, 0, 0);
    step(0, 1, 5'b00000, 5'b00010, 27'h0, 1, 0, 0);   // R-type, unlisted alu

    // 5: full FIFO push+pop, drain, pop on empty
    step(0, 1, 5'b00000, 5'b00000, 27'h0, 1, 0, 1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 5'b00000, 5'b00000, 27'h0, 0, 0, 1);
    step(0, 0, 5'b00000, 5'b00000, 27'h0, 0, 0, 1);
    step(0, 1, 5'b00101, 5'b00000, 27'h0, 1, 0, 1);   // push+pop on empty

    // 6: saturation of the narrow counter
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'b00000, 5'b00001, 27'h0, 1, 0, 0);

    // clear with pending instruction still pops; then mid-stream reset
    step(0, 1, 5'b00000, 5'b00110, 27'h0, 1, 1, 1);
    step(1, 1, 5'b10101, 5'b00000, 27'h123, 1, 0, 1);
    step(0, 0, 5'b00000, 5'b00000, 27'h0, 0, 0, 0);

    chk("scoreboard_empty", 32'(exq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
